// File: rtl/inv_controller_if.sv
// Control bundle between the inverse AES sequencer and the byte-serial datapath.
// The controller drives everything except start, which comes from the host side.
interface inv_controller_if;
  logic       start;
  logic       busy;
  logic       ShowRcon;
  logic       DoInvSR;
  logic       DoInvMC;
  logic       state_reg_hold;
  logic       key_reg_hold;
  logic       DoKeySbox;
  logic       JustFirstColShift;
  logic       Done;
  logic       CorrectPlaintext;
  logic       output_sel;
  logic [1:0] KeyIn_sel;
  logic [1:0] SboxIn_sel;
  logic [7:0] Rcon;

  modport master (
    input  start,
    output busy, ShowRcon, DoInvSR, DoInvMC, state_reg_hold, key_reg_hold,
           DoKeySbox, JustFirstColShift, Done, CorrectPlaintext, output_sel,
           KeyIn_sel, SboxIn_sel, Rcon
  );

  modport slave (
    output start,
    input  busy, ShowRcon, DoInvSR, DoInvMC, state_reg_hold, key_reg_hold,
           DoKeySbox, JustFirstColShift, Done, CorrectPlaintext, output_sel,
           KeyIn_sel, SboxIn_sel, Rcon
  );
endinterface

// File: rtl/inv_controller.sv
// Sequencer for the byte-serial masked AES-128 decryption core: a load phase
// followed by ten inverse rounds, with the inverse key schedule stepped alongside.
module inv_controller #(
  parameter int FinalRoundNumber = 10,
  parameter int LoadCycles       = 20,
  parameter int RoundCycles      = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  inv_controller_if.master  ctrl
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2} state_e;

  localparam logic [4:0] LastLoadPer  = 5'(LoadCycles - 1);
  localparam logic [4:0] LastRoundPer = 5'(RoundCycles - 1);
  localparam logic [3:0] FinalRound   = 4'(FinalRoundNumber);
  localparam logic [7:0] FirstRcon    = 8'h36;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [4:0] per_q, per_d;
  logic [7:0] rcon_q, rcon_d;

  logic validLoad, validRound, finalRound;

  // Steps the round constant backwards: the inverse of multiplication by x in GF(2^8).
  function automatic logic [7:0] invXtime(input logic [7:0] b);
    if (b[0]) return ((b ^ 8'h1B) >> 1) | 8'h80;
    else      return b >> 1;
  endfunction

  assign validLoad  = (state_q == LOAD) && (per_q <= LastLoadPer);
  assign validRound = (state_q == ROUND) && (round_q >= 4'd1) &&
                      (round_q <= FinalRound) && (per_q <= LastRoundPer);
  assign finalRound = (round_q == FinalRound);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    per_d   = per_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      IDLE: begin
        rcon_d = FirstRcon;
        if (ctrl.start) begin
          state_d = LOAD;
          round_d = 4'd0;
          per_d   = 5'd0;
        end
      end
      LOAD: begin
        if (!validLoad) begin
          state_d = IDLE;
          round_d = 4'd0;
          per_d   = 5'd0;
          rcon_d  = FirstRcon;
        end else if (per_q == LastLoadPer) begin
          state_d = ROUND;
          round_d = 4'd1;
          per_d   = 5'd0;
        end else begin
          per_d = per_q + 5'd1;
        end
      end
      ROUND: begin
        // Leaving the final round (or any corrupted encoding) rearms for the next run.
        if (!validRound || (finalRound && per_q == LastRoundPer)) begin
          state_d = IDLE;
          round_d = 4'd0;
          per_d   = 5'd0;
          rcon_d  = FirstRcon;
        end else if (per_q == LastRoundPer) begin
          round_d = round_q + 4'd1;
          per_d   = 5'd0;
          rcon_d  = invXtime(rcon_q);
        end else begin
          per_d = per_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
        per_d   = 5'd0;
        rcon_d  = FirstRcon;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      per_q   <= 5'd0;
      rcon_q  <= FirstRcon;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      per_q   <= per_d;
      rcon_q  <= rcon_d;
    end
  end

  // Datapath controls decode straight from the counters; IDLE values are the fallback.
  always_comb begin
    ctrl.busy              = 1'b0;
    ctrl.ShowRcon          = 1'b0;
    ctrl.DoInvSR           = 1'b0;
    ctrl.DoInvMC           = 1'b0;
    ctrl.state_reg_hold    = 1'b1;
    ctrl.key_reg_hold      = 1'b1;
    ctrl.DoKeySbox         = 1'b0;
    ctrl.JustFirstColShift = 1'b0;
    ctrl.Done              = 1'b0;
    ctrl.CorrectPlaintext  = 1'b0;
    ctrl.output_sel        = 1'b1;
    ctrl.KeyIn_sel         = 2'd0;
    ctrl.SboxIn_sel        = 2'd0;
    ctrl.Rcon              = FirstRcon;
    if (validLoad) begin
      ctrl.busy = 1'b1;
      ctrl.Rcon = rcon_q;
      if (per_q <= 5'd15) begin
        ctrl.state_reg_hold = 1'b0;
        ctrl.key_reg_hold   = 1'b0;
      end else begin
        ctrl.DoKeySbox  = 1'b1;
        ctrl.SboxIn_sel = 2'd1;
      end
    end else if (validRound) begin
      ctrl.busy       = 1'b1;
      ctrl.Rcon       = rcon_q;
      ctrl.KeyIn_sel  = 2'd2;
      ctrl.SboxIn_sel = 2'd3;
      if (per_q <= 5'd1) ctrl.key_reg_hold = 1'b0;
      if (per_q == 5'd2) begin
        ctrl.state_reg_hold    = 1'b0;
        ctrl.DoInvSR           = 1'b1;
        ctrl.JustFirstColShift = 1'b1;
      end
      if (per_q == 5'd3) ctrl.ShowRcon = 1'b1;
      if (per_q >= 5'd3 && per_q <= 5'd6) begin
        ctrl.KeyIn_sel  = 2'd1;
        ctrl.SboxIn_sel = 2'd2;
      end
      if (!finalRound && per_q[1:0] == 2'd3 && per_q <= 5'd15) ctrl.DoInvMC = 1'b1;
      if (per_q >= 5'd19) begin
        ctrl.DoKeySbox  = 1'b1;
        ctrl.SboxIn_sel = 2'd1;
      end
      if (finalRound) begin
        if (per_q >= 5'd3 && per_q <= 5'd6)  ctrl.output_sel       = 1'b0;
        if (per_q >= 5'd3 && per_q <= 5'd18) ctrl.Done             = 1'b1;
        if (per_q == 5'd4)                   ctrl.CorrectPlaintext = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inv_controller.sv
// Directed bench for inv_controller: reset values, full-run timing and
// control decode, Rcon sequence, ignored start pulses and back-to-back runs.
module tb_inv_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  inv_controller_if bus ();

  inv_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  // Bit order: busy ShowRcon DoInvSR DoInvMC srHold krHold DoKeySbox JFCS Done CP osel KeyIn[2] SboxIn[2] Rcon[8]
  localparam logic [22:0] IdleVec = 23'b0_0_0_0_1_1_0_0_0_0_1_00_00_00110110;

  int          spotK   [14] = '{1, 17, 21, 23, 24, 28, 40, 44, 228, 231, 232, 235, 250, 251};
  logic [22:0] spotVec [14] = '{
    23'b1_0_0_0_0_0_0_0_0_0_1_00_00_00110110,
    23'b1_0_0_0_1_1_1_0_0_0_1_00_01_00110110,
    23'b1_0_0_0_1_0_0_0_0_0_1_10_11_00110110,
    23'b1_0_1_0_0_1_0_1_0_0_1_10_11_00110110,
    23'b1_1_0_1_1_1_0_0_0_0_1_01_10_00110110,
    23'b1_0_0_1_1_1_0_0_0_0_1_10_11_00110110,
    23'b1_0_0_0_1_1_1_0_0_0_1_10_01_00110110,
    23'b1_0_0_0_1_0_0_0_0_0_1_10_11_00011011,
    23'b1_0_0_0_1_0_0_0_0_0_1_10_11_00000001,
    23'b1_1_0_0_1_1_0_0_1_0_0_01_10_00000001,
    23'b1_0_0_0_1_1_0_0_1_1_0_01_10_00000001,
    23'b1_0_0_0_1_1_0_0_1_0_1_10_11_00000001,
    23'b1_0_0_0_1_1_1_0_0_0_1_10_01_00000001,
    23'b0_0_0_0_1_1_0_0_0_0_1_00_00_00110110
  };
  logic [7:0] rconExp [10] = '{8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function logic [22:0] snap();
    return {bus.busy, bus.ShowRcon, bus.DoInvSR, bus.DoInvMC, bus.state_reg_hold,
            bus.key_reg_hold, bus.DoKeySbox, bus.JustFirstColShift, bus.Done,
            bus.CorrectPlaintext, bus.output_sel, bus.KeyIn_sel, bus.SboxIn_sel, bus.Rcon};
  endfunction

  // Accepts a start at the next rising edge; returns just after that edge.
  task kick();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task test_reset();
    logic [22:0] v;
    rst_n = 1'b0;
    bus.start = 1'b0;
    #12;
    v = snap();
    compared++;
    if (v !== IdleVec) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b want %b", v, IdleVec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    v = snap();
    compared++;
    if (v !== IdleVec) begin
      mismatched++;
      $display("[TB] FAIL idle_no_start: got %b want %b", v, IdleVec);
    end
  endtask

  task test_full_run();
    logic [22:0] v;
    logic [7:0]  rconSeen [10];
    int busyCnt = 0, doneCnt = 0, firstDone = -1, lastDone = -1;
    int cpCnt = 0, cpAt = -1, mcCnt = 0, mcFinal = 0, rconIdx = 0;
    kick();
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      v = snap();
      if (v[22]) busyCnt++;
      if (v[14]) begin
        doneCnt++;
        if (firstDone < 0) firstDone = k;
        lastDone = k;
      end
      if (v[13]) begin
        cpCnt++;
        cpAt = k;
      end
      if (v[19]) begin
        mcCnt++;
        if (k >= 228) mcFinal++;
      end
      if (v[21]) begin
        if (rconIdx < 10) rconSeen[rconIdx] = v[7:0];
        rconIdx++;
      end
      for (int i = 0; i < 14; i++) begin
        if (k == spotK[i]) begin
          compared++;
          if (v !== spotVec[i]) begin
            mismatched++;
            $display("[TB] FAIL decode_k%0d: got %b want %b", k, v, spotVec[i]);
          end
        end
      end
    end
    compared++;
    if (busyCnt !== 250) begin mismatched++; $display("[TB] FAIL busy_cycles: got %0d want 250", busyCnt); end
    compared++;
    if (doneCnt !== 16) begin mismatched++; $display("[TB] FAIL done_cycles: got %0d want 16", doneCnt); end
    compared++;
    if (firstDone !== 231 || lastDone !== 246) begin
      mismatched++;
      $display("[TB] FAIL done_window: got %0d..%0d want 231..246", firstDone, lastDone);
    end
    compared++;
    if (cpCnt !== 1 || cpAt !== 232) begin
      mismatched++;
      $display("[TB] FAIL correct_plaintext: got %0d pulses at %0d want 1 at 232", cpCnt, cpAt);
    end
    compared++;
    if (mcCnt !== 36 || mcFinal !== 0) begin
      mismatched++;
      $display("[TB] FAIL invmc_count: got %0d (final %0d) want 36 (final 0)", mcCnt, mcFinal);
    end
    compared++;
    if (rconIdx !== 10) begin
      mismatched++;
      $display("[TB] FAIL showrcon_count: got %0d want 10", rconIdx);
    end else begin
      for (int i = 0; i < 10; i++) begin
        compared++;
        if (rconSeen[i] !== rconExp[i]) begin
          mismatched++;
          $display("[TB] FAIL rcon_round%0d: got %h want %h", i + 1, rconSeen[i], rconExp[i]);
        end
      end
    end
  endtask

  task test_start_ignored();
    logic [22:0] v;
    int busyCnt = 0, firstDone = -1;
    kick();
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      bus.start = (k == 5 || k == 100);
      v = snap();
      if (v[22]) busyCnt++;
      if (v[14] && firstDone < 0) firstDone = k;
      if (k == 6 || k == 101) begin
        compared++;
        if (v[22] !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL busy_after_start_pulse_k%0d: got %b want 1", k, v[22]);
        end
      end
    end
    bus.start = 1'b0;
    compared++;
    if (busyCnt !== 250 || firstDone !== 231) begin
      mismatched++;
      $display("[TB] FAIL start_ignored_timing: got busy %0d done@%0d want 250 done@231", busyCnt, firstDone);
    end
  endtask

  task test_reset_mid_round();
    logic [22:0] v;
    kick();
    // k=122 is round 5, Per 9
    repeat (122) @(negedge clk);
    v = snap();
    compared++;
    if (v[22] !== 1'b1 || v[7:0] !== 8'h20) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_round5: got busy %b rcon %h want 1 20", v[22], v[7:0]);
    end
    #2 rst_n = 1'b0;
    #1 v = snap();
    compared++;
    if (v !== IdleVec) begin
      mismatched++;
      $display("[TB] FAIL async_reset_outputs: got %b want %b", v, IdleVec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = snap();
    compared++;
    if (v !== IdleVec) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle: got %b want %b", v, IdleVec);
    end
  endtask

  task test_back_to_back();
    logic [22:0] v;
    int busyCnt = 0;
    bit idleSeen = 1'b0;
    kick();
    bus.start = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      v = snap();
      if (k <= 250 && v[22]) busyCnt++;
      if (k == 251) begin
        compared++;
        if (v !== IdleVec) begin
          mismatched++;
          $display("[TB] FAIL b2b_idle_gap: got %b want %b", v, IdleVec);
        end
      end
      if (k == 252) begin
        compared++;
        if (v !== spotVec[0]) begin
          mismatched++;
          $display("[TB] FAIL b2b_restart: got %b want %b", v, spotVec[0]);
        end
      end
    end
    compared++;
    if (busyCnt !== 250) begin
      mismatched++;
      $display("[TB] FAIL b2b_busy_cycles: got %0d want 250", busyCnt);
    end
    bus.start = 1'b0;
    for (int k = 0; k < 300 && !idleSeen; k++) begin
      @(negedge clk);
      if (!bus.busy) idleSeen = 1'b1;
    end
    compared++;
    if (!idleSeen) begin
      mismatched++;
      $display("[TB] FAIL b2b_drain_timeout: got busy still 1 want 0");
    end
  endtask

  initial begin
    bus.start = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_full_run();
    test_start_ignored();
    test_reset_mid_round();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
